// File: rtl/pl_dac_pkg.sv
// Shared types and constants for the PL DAC transmit stream path.
package pl_dac_pkg;

  // Width of the AXI4-Stream data bus coming from the PS/DMA side.
  localparam int AXIS_W = 16;

  // Width of the transfer-control state encoding.
  localparam int STATE_W = 2;

  // Transfer-control states.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pl_dac_fifo.sv
// Single-clock sample FIFO with a synchronous flush.
// The read port shows the head entry whenever the FIFO is non-empty.
module pl_dac_fifo #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            push_i,
  input  logic [DATA_W-1:0]               wdata_i,
  input  logic                            pop_i,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // The extra pointer bit tells full from empty when the indices are equal.
  logic [LW-1:0]     wptr_q;
  logic [LW-1:0]     rptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == LW'(FIFO_DEPTH));
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer update; flush empties the FIFO on the next edge and wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + LW'(1);
      if (do_pop)  rptr_q <= rptr_q + LW'(1);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; entries are only read after being written, so a reset would only cost routing.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pl_dac_stream.sv
// AXI4-Stream to parallel CMOS DAC transmit path with work/done handshake.
// Optional tlast framing check is compiled in with `define DAC_LAST_CHECK_EN.
module pl_dac_stream
  import pl_dac_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 4,
  parameter int COUNT_W    = 32
) (
  input  logic               i_CMOS_Clk,
  input  logic               i_CMOS_Rst_n,
  input  logic [AXIS_W-1:0]  i_S_Axis_Tdata,
  input  logic               i_S_Axis_Tvalid,
  output logic               o_S_Axis_Tready,
  input  logic               i_S_Axis_Tlast,
  input  logic               i_DAC_Work,
  input  logic [COUNT_W-1:0] i_Count,
  output logic [DATA_W-1:0]  o_CMOS_Data,
  output logic               o_DAC_Valid,
  output logic               o_DAC_Done,
  output logic               o_DAC_Underrun
`ifdef DAC_LAST_CHECK_EN
  ,
  output logic               o_DAC_Last_Err
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

  state_e             state_q;
  logic [COUNT_W-1:0] cnt_lat_q;
  logic [COUNT_W-1:0] rx_cnt_q;
  logic [COUNT_W-1:0] rx_cnt_d;
  logic [COUNT_W-1:0] tx_cnt_q;
  logic [COUNT_W-1:0] tx_cnt_d;
  logic [DATA_W-1:0]  data_q;
  logic               valid_q;
  logic               done_q;
  logic               underrun_q;

  logic               active;
  logic               start;
  logic               abort;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [DATA_W-1:0]  fifo_rdata;

  // Handshake and datapath control, all derived from registered state so
  // tready never depends on tvalid.
  assign active          = (state_q == ST_PREFILL) || (state_q == ST_RUN);
  assign start           = (state_q == ST_IDLE) && i_DAC_Work && !done_q;
  assign abort           = active && !i_DAC_Work;
  assign o_S_Axis_Tready = active && !fifo_full && (rx_cnt_q != cnt_lat_q);
  assign push            = i_S_Axis_Tvalid && o_S_Axis_Tready;
  assign pop             = (state_q == ST_RUN) && !abort && !fifo_empty;
  assign rx_cnt_d        = rx_cnt_q + COUNT_W'(1);
  assign tx_cnt_d        = tx_cnt_q + COUNT_W'(1);

  assign o_CMOS_Data    = data_q;
  assign o_DAC_Valid    = valid_q;
  assign o_DAC_Done     = done_q;
  assign o_DAC_Underrun = underrun_q;

  pl_dac_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_CMOS_Clk),
    .rst_ni  (i_CMOS_Rst_n),
    .flush_i (abort),
    .push_i  (push),
    .wdata_i (i_S_Axis_Tdata[DATA_W-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Transfer FSM with registered DAC bus, valid, done and underrun outputs.
  always_ff @(posedge i_CMOS_Clk or negedge i_CMOS_Rst_n) begin
    if (!i_CMOS_Rst_n) begin
      state_q    <= ST_IDLE;
      cnt_lat_q  <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push) rx_cnt_q <= rx_cnt_d;
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            cnt_lat_q  <= i_Count;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            underrun_q <= 1'b0;
            if (i_Count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_PREFILL;
            end
          end
        end
        ST_PREFILL: begin
          if (!i_DAC_Work) begin
            state_q <= ST_IDLE;
          end else if ((fifo_level >= PREFILL_LVL) || (rx_cnt_q == cnt_lat_q)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!i_DAC_Work) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end else if (!fifo_empty) begin
            data_q   <= fifo_rdata;
            valid_q  <= 1'b1;
            tx_cnt_q <= tx_cnt_d;
            if (tx_cnt_d == cnt_lat_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            valid_q    <= 1'b0;
            underrun_q <= 1'b1;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          if (!i_DAC_Work) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DAC_LAST_CHECK_EN
  logic last_err_q;
  logic unused_axis;

  assign o_DAC_Last_Err = last_err_q;
  assign unused_axis    = ^i_S_Axis_Tdata[AXIS_W-1:DATA_W];

  // Sticky framing error: tlast must mark exactly the final beat of the transfer.
  always_ff @(posedge i_CMOS_Clk or negedge i_CMOS_Rst_n) begin
    if (!i_CMOS_Rst_n) begin
      last_err_q <= 1'b0;
    end else if (start) begin
      last_err_q <= 1'b0;
    end else if (push && (i_S_Axis_Tlast != (rx_cnt_d == cnt_lat_q))) begin
      last_err_q <= 1'b1;
    end
  end
`else
  logic unused_axis;

  assign unused_axis = ^{i_S_Axis_Tdata[AXIS_W-1:DATA_W], i_S_Axis_Tlast};
`endif

endmodule

// File: doc/pl_dac_stream.md
Name: pl_dac_stream

Overview:
- Transmit-side counterpart of the PL ADC capture path.
- Consumes an AXI4-Stream sample stream from the PS/DMA side, buffers it in a small FIFO, and drives a 12-bit parallel CMOS DAC bus at one sample per clock.
- Runs a work/done handshake with a programmable sample count, mirroring the ADC capture control.
- Sits between the DMA stream slave and the DAC pins, all in the CMOS clock domain.

Parameters:
- DATA_W, 12, DAC sample width; taken from tdata[DATA_W-1:0].
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- PREFILL, 4, samples buffered before output starts; must satisfy 1 <= PREFILL <= FIFO_DEPTH.
- COUNT_W, 32, width of the sample count.

Ports:
- i_CMOS_Clk  in  1  sole clock.
- i_CMOS_Rst_n  in  1  asynchronous reset, active-low.
- i_S_Axis_Tdata  in  16  sample in; bits [15:DATA_W] ignored.
- i_S_Axis_Tvalid  in  1  AXIS valid.
- o_S_Axis_Tready  out  1  AXIS ready.
- i_S_Axis_Tlast  in  1  AXIS last; used only by the optional feature.
- i_DAC_Work  in  1  level-sensitive start/enable.
- i_Count  in  COUNT_W  number of samples to emit; latched at start.
- o_CMOS_Data  out  DATA_W  DAC bus, registered.
- o_DAC_Valid  out  1  high in every cycle a new sample is on o_CMOS_Data.
- o_DAC_Done  out  1  transfer complete.
- o_DAC_Underrun  out  1  sticky per transfer; FIFO ran empty during RUN.
- o_DAC_Last_Err  out  1  present only with DAC_LAST_CHECK_EN.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0; state goes to IDLE.
  - FIFO pointers and counters clear immediately, without waiting for a clock edge.
- Counters:
  - rx_cnt counts accepted beats; tx_cnt counts emitted samples.
  - Both are COUNT_W wide, compared with the latched count using unsigned equality.
- Accept rule: o_S_Axis_Tready = (state==PREFILL or RUN) and FIFO not full and rx_cnt != cnt_lat.
  - A beat is accepted only when tvalid and tready are both high; tready is registered-safe and has no combinational path from tvalid.
- IDLE:
  - o_S_Axis_Tready=0 and o_DAC_Valid=0; o_CMOS_Data holds its last value.
  - When i_DAC_Work=1 and o_DAC_Done=0: latch i_Count, clear both counters and o_DAC_Underrun.
  - If the latched count is 0, go to DONE; otherwise go to PREFILL.
- PREFILL:
  - Accept beats.
  - Go to RUN when FIFO level >= PREFILL or rx_cnt == cnt_lat.
- RUN, each cycle:
  - FIFO non-empty: pop; o_CMOS_Data <= sample (1 cycle from pop); o_DAC_Valid <= 1; tx_cnt++.
  - FIFO empty: o_DAC_Valid <= 0; o_CMOS_Data holds; o_DAC_Underrun <= 1; tx_cnt unchanged.
  - Push and pop in the same cycle are legal; the level is unchanged.
  - When the pop makes tx_cnt == cnt_lat, go to DONE on the next edge.
- DONE:
  - o_DAC_Done=1 and tready=0.
  - Stays in DONE until i_DAC_Work=0, then clears o_DAC_Done and returns to IDLE.
  - A new start therefore requires i_DAC_Work to go low and then high again.
- Abort: i_DAC_Work=0 in PREFILL or RUN:
  - Next edge goes to IDLE and flushes the FIFO.
  - o_DAC_Done stays 0; o_DAC_Underrun holds until the next start.
- Latency: first o_DAC_Valid comes PREFILL+2 cycles after start when tvalid is held high.

Optional Feature:
- Macro: DAC_LAST_CHECK_EN.
- Defined:
  - o_DAC_Last_Err is sticky per transfer and is cleared at start.
  - It sets when an accepted beat has tlast=1 with rx_cnt+1 != cnt_lat.
  - It also sets when the beat making rx_cnt+1 == cnt_lat has tlast=0.
- Undefined:
  - The port and all checking logic are absent; tlast is ignored.

Decomposition:
- Package pl_dac_pkg holds:
  - the state enum (IDLE, PREFILL, RUN, DONE);
  - the state encoding width;
  - the localparam AXIS_W=16.
- One sub-module, pl_dac_fifo:
  - synchronous single-clock FIFO with asynchronous active-low reset;
  - ports for push, pop, full, empty, level, and a synchronous flush;
  - parameterised by DATA_W and FIFO_DEPTH.

Test Plan:
- Nominal run: count=8, tvalid held high, data 0..7 -> o_CMOS_Data=0..7 with o_DAC_Valid high in 8 consecutive cycles, first valid PREFILL+2 cycles after start; o_DAC_Done=1 afterwards; underrun=0.
- Zero count: count=0 -> o_DAC_Done=1 one cycle after work rises; tready never asserts; o_DAC_Valid stays 0.
- Source stall: count=10, PREFILL=4, source stalls 6 cycles after beat 5 -> o_DAC_Underrun=1; o_DAC_Valid low while empty; o_CMOS_Data holds 4; exactly 10 valids in total; Done asserts.
- Abort: count=100, drop i_DAC_Work after 20 valids -> IDLE next edge; tready=0; Done=0; next start with count=3 emits exactly 3 fresh samples.
- Asynchronous reset: assert i_CMOS_Rst_n=0 mid-RUN between clock edges -> all outputs 0 immediately; after release, IDLE with empty FIFO.
- Last check (DAC_LAST_CHECK_EN): count=8, tlast on beat 6 -> o_DAC_Last_Err=1. Same test with tlast on beat 8 -> o_DAC_Last_Err=0.
